// File: rtl/addsub_multiword_seq_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
//   Shared types and helpers for the multi-word add/subtract sequencer.
//   - state_e   : sequencer FSM states (IDLE, RUN, DONE), 2-bit encoding
//   - idx_w()   : width of the limb index register for a given limb count,
//                 never less than 1 so WORDS=1 still has a legal register
//   - sat_value(): saturated two's-complement value of a given width
//                 (0x7F..F for positive, 0x80..0 for negative), returned in a
//                 SAT_MAX_W container; callers slice the low bits they need.
//                 Only used when ADDSUB_SAT_EN is defined.
// -----------------------------------------------------------------------------
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MAX_WORDS = 16;
    localparam int SAT_MAX_W = 256;

    function automatic int idx_w(input int words);
        int w;
        w = $clog2(words);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_value(input int width, input logic neg);
        logic [SAT_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            if (i < width - 1) begin
                v[i] = ~neg;
            end else if (i == width - 1) begin
                v[i] = neg;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/addsub_multiword_seq_limb.sv
// -----------------------------------------------------------------------------
// addsub_limb
//   One n-bit combinational add/subtract slice. The sequencer feeds it one limb
//   per clock and registers the carry between limbs.
//   Ports:
//     a, b      in  n  operand limbs
//     cin       in  1  carry in (the sequencer seeds it with add_n for limb 0)
//     add_n     in  1  0 = a+b, 1 = a-b (b is inverted here)
//     r         out n  limb result
//     cout      out 1  carry out of the limb MSB
//     c_msb_in  out 1  carry into the limb MSB (for signed overflow on the top limb)
// -----------------------------------------------------------------------------
module addsub_limb #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    input  logic         add_n,
    output logic [n-1:0] r,
    output logic         cout,
    output logic         c_msb_in
);

    logic [n-1:0] b_eff;
    logic [n:0]   sum;

    always_comb begin
        b_eff = b ^ {n{add_n}};
        sum   = {1'b0, a} + {1'b0, b_eff} + {{n{1'b0}}, cin};
        r     = sum[n-1:0];
        cout  = sum[n];
        // The MSB's sum bit is a^b^carry_in, so the carry into it falls out by XOR.
        c_msb_in = a[n-1] ^ b_eff[n-1] ^ sum[n-1];
    end

endmodule

// File: rtl/addsub_multiword_seq.sv
// -----------------------------------------------------------------------------
// addsub_multiword_seq
//   Multi-precision add/subtract sequencer. Captures two W = n*WORDS bit
//   operands and produces the result one n-bit limb per clock, LSW first,
//   through a single shared addsub_limb instance.
//   Parameters: n (limb width), WORDS (limb count, 1..16).
//   Ports:
//     clk       in  1  clock, rising edge
//     rst       in  1  synchronous active-high reset (aborts any operation)
//     start     in  1  request; accepted only while idle
//     add_n     in  1  0 = x+y, 1 = x-y; captured on accept
//     x, y      in  W  two's-complement operands; captured on accept
//     busy      out 1  high from the cycle after accept through the done cycle
//     done      out 1  one-cycle pulse, results valid from this cycle
//     s         out W  result, held until the next accept
//     C_out     out 1  carry out of the MSB (subtract: 1 = no borrow)
//     overflow  out 1  signed overflow of the full W-bit operation
//   Build option: define ADDSUB_SAT_EN to saturate s on signed overflow.
//   Latency: accept at edge T, done high in cycle T+WORDS+1.
// -----------------------------------------------------------------------------
module addsub_multiword_seq
    import addsub_pkg::*;
#(
    parameter int n     = 4,
    parameter int WORDS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               add_n,
    input  logic [n*WORDS-1:0] x,
    input  logic [n*WORDS-1:0] y,
    output logic               busy,
    output logic               done,
    output logic [n*WORDS-1:0] s,
    output logic               C_out,
    output logic               overflow
);

    localparam int W     = n * WORDS;
    localparam int IDX_W = idx_w(WORDS);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [W-1:0]     x_q, x_d;
    logic [W-1:0]     y_q, y_d;
    logic [W-1:0]     s_q, s_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic [n-1:0]     x_limb, y_limb, r_limb;
    logic             cout_limb, c_msb_limb;
    logic             last_limb;

`ifdef ADDSUB_SAT_EN
    logic [SAT_MAX_W-1:0] sat_full;
`endif

    // Select the limb currently being processed.
    always_comb begin
        x_limb    = x_q[int'(idx_q)*n +: n];
        y_limb    = y_q[int'(idx_q)*n +: n];
        last_limb = (int'(idx_q) == WORDS - 1);
    end

    addsub_limb #(
        .n(n)
    ) u_limb (
        .a        (x_limb),
        .b        (y_limb),
        .cin      (carry_q),
        .add_n    (sub_q),
        .r        (r_limb),
        .cout     (cout_limb),
        .c_msb_in (c_msb_limb)
    );

`ifdef ADDSUB_SAT_EN
    always_comb begin
        sat_full = sat_value(W, x_q[W-1]);
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        x_d     = x_q;
        y_d     = y_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    sub_d   = add_n;
                    idx_d   = '0;
                    // Subtraction is x + ~y + 1: the +1 enters as the LSW carry.
                    carry_d = add_n;
                    s_d     = '0;
                    c_out_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end

            RUN: begin
                s_d[int'(idx_q)*n +: n] = r_limb;
                carry_d = cout_limb;
                if (last_limb) begin
                    c_out_d = cout_limb;
                    ovf_d   = c_msb_limb ^ cout_limb;
`ifdef ADDSUB_SAT_EN
                    // Saturate on the final limb so the clamped value is visible with done.
                    if (c_msb_limb ^ cout_limb) begin
                        s_d = sat_full[W-1:0];
                    end
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            DONE: begin
                // start is deliberately ignored here; next accept is from IDLE.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    // Captured operands carry no reset: they are only read while RUN.
    always_ff @(posedge clk) begin
        x_q   <= x_d;
        y_q   <= y_d;
        sub_q <= sub_d;
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        s        = s_q;
        C_out    = c_out_q;
        overflow = ovf_q;
    end

endmodule
